// File: rtl/systolic_skew_feeder_if.sv
// Operand feeder bus: input vector handshake plus skewed per-lane outputs
// and occupancy status toward the systolic PE row.
interface systolic_skew_feeder_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*BITWIDTH-1:0] in_a;
  logic [LANES*BITWIDTH-1:0] in_b;
  logic [LANES*BITWIDTH-1:0] out_a;
  logic [LANES*BITWIDTH-1:0] out_b;
  logic [LANES-1:0]          out_valid;
  logic [CW-1:0]             count;
  logic                      busy;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, out_a, out_b, out_valid, count, busy
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, out_a, out_b, out_valid, count, busy
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers operand vectors, issues them GAP cycles apart and skews lane i by
// i cycles to form the diagonal wavefront a systolic PE row expects.
module systolic_skew_feeder #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GAP      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  systolic_skew_feeder_if.slave  bus
);
  localparam int unsigned W  = LANES * BITWIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mem_a [DEPTH];
  logic [W-1:0]    mem_b [DEPTH];
  logic [W-1:0]    head_a, head_b;
  logic [LANES-1:0] sv_q;
  logic            ready, push, pop;

  assign ready  = cnt_q < CW'(DEPTH);
  assign push   = bus.in_valid && ready && !flush_i;
  assign pop    = (state_q == IDLE) && (cnt_q != '0) && !flush_i;
  assign head_a = mem_a[rd_q];
  assign head_b = mem_b[rd_q];

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      gap_d   = '0;
      cnt_d   = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      case (state_q)
        IDLE: if (pop && (GAP > 1)) begin
          state_d = HOLD;
          gap_d   = GW'(GAP - 1);
        end
        HOLD: if (gap_q == GW'(1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      sv_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
        sv_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
        sv_q <= {sv_q[LANES-2:0], pop};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_q] <= bus.in_a;
      mem_b[wr_q] <= bus.in_b;
    end
  end

  // Each lane keeps only its own operand slice, delayed by a chain of l+1 regs;
  // idle stages carry zeros so out_a/out_b read 0 whenever the lane is invalid.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BITWIDTH-1:0] a_q [l+1];
    logic [BITWIDTH-1:0] b_q [l+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned k = 0; k < l + 1; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else if (flush_i) begin
        for (int unsigned k = 0; k < l + 1; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        a_q[0] <= pop ? head_a[l*BITWIDTH +: BITWIDTH] : '0;
        b_q[0] <= pop ? head_b[l*BITWIDTH +: BITWIDTH] : '0;
        for (int unsigned k = 1; k < l + 1; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end

    assign bus.out_a[l*BITWIDTH +: BITWIDTH] = a_q[l];
    assign bus.out_b[l*BITWIDTH +: BITWIDTH] = b_q[l];
  end

  assign bus.out_valid = sv_q;
  assign bus.in_ready  = ready;
  assign bus.count     = cnt_q;
  assign bus.busy      = (cnt_q != '0) | (|sv_q);
endmodule
